// File: rtl/proj_norm_if.sv
// Handshake and coefficient-write bundle between the projection engine and its host.
interface proj_norm_if #(
    parameter int LANES   = 4,
    parameter int D_WIDTH = 16,
    parameter int ROW_W   = 7,
    parameter int COL_W   = 5
);
    logic                       wr_en;
    logic [ROW_W-1:0]           wr_row;
    logic [COL_W-1:0]           wr_col;
    logic [LANES*D_WIDTH-1:0]   wr_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*D_WIDTH-1:0]   in_pixel;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [2*D_WIDTH-1:0]       norm;
    logic                       busy;

    modport master (
        output wr_en, wr_row, wr_col, wr_data, in_valid, in_pixel, in_last, out_ready,
        input  in_ready, out_valid, norm, busy
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data, in_valid, in_pixel, in_last, out_ready,
        output in_ready, out_valid, norm, busy
    );
endinterface

// File: rtl/proj_norm_engine.sv
// Projection engine: per-row signed dot products over a streamed pixel vector, then a
// sequential squared-norm sweep. Define PROJ_NORM_SAT_EN to saturate the norm slice.
module proj_norm_engine #(
    parameter int ROWS       = 103,
    parameter int COLS       = 26,
    parameter int LANES      = 4,
    parameter int D_WIDTH    = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int SLICE_LSB  = 26,
    parameter int NORM_SHIFT = 10
) (
    input  logic        clk,
    input  logic        rst,
    proj_norm_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for the first beat of a vector
    // ACCUM  | accepting further beats
    // DRAIN  | last beat's products land in the accumulators
    // NORM   | one row accumulator folded into the norm per cycle
    // DONE   | result held until the consumer takes it
    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_NORM, S_DONE} state_t;

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = LANES * D_WIDTH;
    localparam int NW = 2 * D_WIDTH;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic signed [NW-1:0] norm_q, norm_d;
    logic acc_clr;
    logic accept;

    logic [PW-1:0] mem [COLS][ROWS];
    logic [PW-1:0] rd_q [ROWS];
    logic [PW-1:0] pix_q;
    logic beat_q;
    logic signed [ACC_WIDTH-1:0] acc_q [ROWS];
    logic signed [ACC_WIDTH-1:0] dot [ROWS];
    logic signed [D_WIDTH-1:0] s_slice;
    logic signed [NW-1:0] term;

    assign bus.in_ready  = !rst && (state_q == S_IDLE || state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.norm      = norm_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Coefficient RAM is never reset; same-cycle write/read returns the old word.
    always_ff @(posedge clk) begin
        if (bus.wr_en && int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS)
            mem[bus.wr_col][bus.wr_row] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) beat_q <= 1'b0;
        else     beat_q <= accept;
        if (accept) begin
            for (int r = 0; r < ROWS; r++) rd_q[r] <= mem[col_q][r];
            pix_q <= bus.in_pixel;
        end
    end

    always_comb begin
        logic signed [NW-1:0] a_x, b_x, prod;
        for (int r = 0; r < ROWS; r++) begin
            dot[r] = '0;
            for (int k = 0; k < LANES; k++) begin
                a_x    = NW'($signed(rd_q[r][k*D_WIDTH +: D_WIDTH]));
                b_x    = NW'($signed(pix_q[k*D_WIDTH +: D_WIDTH]));
                prod   = a_x * b_x;
                dot[r] = dot[r] + {{(ACC_WIDTH-NW){prod[NW-1]}}, prod};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (rst || acc_clr) acc_q[r] <= '0;
            else if (beat_q)    acc_q[r] <= acc_q[r] + dot[r];
        end
    end

`ifdef PROJ_NORM_SAT_EN
    localparam logic signed [D_WIDTH-1:0]   SD_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0]   SD_MIN = ~SD_MAX;
    localparam logic signed [ACC_WIDTH-1:0] SA_MAX = ACC_WIDTH'(SD_MAX);
    localparam logic signed [ACC_WIDTH-1:0] SA_MIN = ACC_WIDTH'(SD_MIN);
    logic signed [ACC_WIDTH-1:0] acc_sh;

    always_comb begin
        acc_sh = acc_q[row_q] >>> SLICE_LSB;
        if (acc_sh > SA_MAX)      s_slice = SD_MAX;
        else if (acc_sh < SA_MIN) s_slice = SD_MIN;
        else                      s_slice = acc_sh[D_WIDTH-1:0];
    end
`else
    always_comb begin
        s_slice = acc_q[row_q][SLICE_LSB +: D_WIDTH];
    end
`endif

    always_comb begin
        logic signed [NW-1:0] s_x, sq;
        s_x  = NW'(s_slice);
        sq   = s_x * s_x;
        term = sq >>> NORM_SHIFT;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        norm_d  = norm_q;
        acc_clr = 1'b0;
        if (accept)
            col_d = (bus.in_last || col_q == COL_LAST) ? '0 : col_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = bus.in_last ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                if (accept && bus.in_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_NORM;
                row_d   = '0;
                norm_d  = '0;
            end
            S_NORM: begin
                norm_d = norm_q + term;
                if (row_q == ROW_LAST) state_d = S_DONE;
                else                   row_d   = row_q + 1'b1;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    norm_d  = '0;
                    acc_clr = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            norm_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            norm_q  <= norm_d;
        end
    end
endmodule

// File: tb/tb_proj_norm_engine.sv
// Self-checking bench for proj_norm_engine against a plain-arithmetic model of the projection.
module tb_proj_norm_engine;
    localparam int ROWS = 4, COLS = 2, LANES = 4, DW = 16, AW = 48, SLICE = 0, NSH = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    proj_norm_if #(.LANES(LANES), .D_WIDTH(DW), .ROW_W(2), .COL_W(1)) bus();

    proj_norm_engine #(
        .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .D_WIDTH(DW),
        .ACC_WIDTH(AW), .SLICE_LSB(SLICE), .NORM_SHIFT(NSH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     coef_m [ROWS][COLS][LANES];
    longint acc_m  [ROWS];
    int     col_m;
    longint exp_norm;
    bit     exp_ok;
    longint last_norm;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - AW)) >>> (64 - AW);
    endfunction

    function automatic longint slice_of(input longint a);
        longint sh;
        sh = a >>> SLICE;
`ifdef PROJ_NORM_SAT_EN
        if (sh > 32767)  return 32767;
        if (sh < -32768) return -32768;
        return sh;
`else
        return (sh <<< (64 - DW)) >>> (64 - DW);
`endif
    endfunction

    function automatic longint model_norm();
        longint sum, s;
        sum = 0;
        for (int r = 0; r < ROWS; r++) begin
            s   = slice_of(acc_m[r]);
            sum = sum + ((s * s) >>> NSH);
        end
        return longint'(int'(sum));
    endfunction

    function automatic logic [63:0] rep(input int v);
        logic [63:0] d;
        for (int k = 0; k < LANES; k++) d[k*DW +: DW] = DW'(v);
        return d;
    endfunction

    task automatic model_write(input int r, input int c, input logic [63:0] d);
        for (int k = 0; k < LANES; k++) coef_m[r][c][k] = int'($signed(d[k*DW +: DW]));
    endtask

    task automatic wr_word(input int r, input int c, input logic [63:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 1'(c);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        model_write(r, c, d);
    endtask

    task automatic fill(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wr_word(r, c, rep(v));
    endtask

    task automatic send_beat(input logic [63:0] pix, input bit last, input bit coll,
                             input int cr, input int cc, input logic [63:0] cd);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = pix;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("in_ready wait timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (coll) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = 2'(cr);
            bus.wr_col  = 1'(cc);
            bus.wr_data = cd;
        end
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < LANES; k++)
                acc_m[r] = wrap_acc(acc_m[r] + longint'(coef_m[r][col_m][k]) *
                                    longint'($signed(pix[k*DW +: DW])));
        col_m = last ? 0 : (col_m + 1) % COLS;
        if (coll) model_write(cr, cc, cd);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.wr_en    = 1'b0;
    endtask

    task automatic collect(input int hold);
        int lat;
        exp_norm  = model_norm();
        exp_ok    = 1'b1;
        last_norm = -1;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid latency", lat, ROWS + 1);
        last_norm = $signed(bus.norm);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = {$urandom, $urandom};
            bus.in_last  = 1'($urandom_range(0, 1));
            check("in_ready while result pending", bus.in_ready, 0);
            @(negedge clk);
            check("norm stable under backpressure", $signed(bus.norm), last_norm);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid after handshake", bus.out_valid, 0);
        check("in_ready after handshake", bus.in_ready, 1);
        exp_ok = 1'b0;
        for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
    endtask

    task automatic basic_vector();
        send_beat(rep(2), 1'b0, 1'b0, 0, 0, 64'd0);
        send_beat(rep(2), 1'b1, 1'b0, 0, 0, 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && exp_ok)
                check("norm vs model", $signed(bus.norm), exp_norm);
            if (bus.out_valid && bus.in_ready)
                check("in_ready low while out_valid", bus.in_ready, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_valid;
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
        bus.in_valid = 1'b0; bus.in_pixel = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        exp_ok = 1'b0; col_m = 0; exp_norm = 0; last_norm = 0;

        for (int r = 0; r < ROWS; r++) acc_m[r] = 16;
        check("model basic norm", model_norm(), 1024);
        for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
        acc_m[0] = 40000;
`ifdef PROJ_NORM_SAT_EN
        check("model overflow norm", model_norm(), 1073676289);
`else
        check("model overflow norm", model_norm(), 652087296);
`endif
        acc_m[0] = 0;

        repeat (3) @(negedge clk);
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset norm", bus.norm, 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", bus.in_ready, 1);
        @(negedge clk);

        // basic vector
        fill(1);
        basic_vector();
        collect(0);
        check("basic norm", last_norm, 1024);

        // backpressure, then a fresh vector on cleared accumulators
        basic_vector();
        collect(10);
        check("backpressure norm", last_norm, 1024);
        basic_vector();
        collect(0);
        check("norm after backpressure", last_norm, 1024);

        // same-cycle write to the column being read
        send_beat(rep(2), 1'b0, 1'b1, 0, 0, rep(3));
        for (int r = 1; r < ROWS; r++) wr_word(r, 0, rep(3));
        send_beat(rep(2), 1'b1, 1'b0, 0, 0, 64'd0);
        collect(0);
        check("collision uses old word", last_norm, 1024);
        basic_vector();
        collect(0);
        check("vector after collision", last_norm, 4096);

        // overflowing slice
        wr_word(0, 0, rep(200));
        for (int r = 1; r < ROWS; r++) wr_word(r, 0, rep(0));
        send_beat(rep(50), 1'b1, 1'b0, 0, 0, 64'd0);
        collect(0);
`ifdef PROJ_NORM_SAT_EN
        check("overflow norm saturated", last_norm, 1073676289);
`else
        check("overflow norm truncated", last_norm, 652087296);
`endif

        // column wrap, then confirm the column counter restarted at 0
        fill(1);
        for (int b = 0; b < 4; b++) send_beat(rep(1), b == 3, 1'b0, 0, 0, 64'd0);
        collect(0);
        check("column wrap norm", last_norm, 1024);
        for (int r = 0; r < ROWS; r++) wr_word(r, 0, rep(2));
        send_beat(rep(1), 1'b1, 1'b0, 0, 0, 64'd0);
        collect(0);
        check("col restarts at 0", last_norm, 256);

        // reset in the second NORM cycle
        fill(1);
        basic_vector();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("out_valid during mid-NORM reset", bus.out_valid, 0);
        check("busy after mid-NORM reset", bus.busy, 0);
        rst = 1'b0;
        for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
        col_m = 0;
        any_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) any_valid = 1'b1;
        end
        check("no result after reset", any_valid, 0);
        basic_vector();
        collect(0);
        check("norm after mid-NORM reset", last_norm, 1024);

        // randomized vectors
        for (int v = 0; v < 30; v++) begin
            int nwr, len, hold;
            nwr = $urandom_range(0, 4);
            for (int i = 0; i < nwr; i++)
                wr_word($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), {$urandom, $urandom});
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                bit coll;
                coll = ($urandom_range(0, 3) == 0);
                send_beat({$urandom, $urandom}, b == len-1, coll,
                          $urandom_range(0, ROWS-1), $urandom_range(0, COLS-1), {$urandom, $urandom});
                if (b != len-1) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            hold = $urandom_range(0, 3);
            collect(hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
